// File: rtl/io_port_unit.sv
// io_port_unit: memory-mapped I/O target for ports B, C and D.
// Holds PORTx/DDRx, synchronizes the external pins into PINx and answers each
// single-cycle OUT/IN request with a registered read result and a one-cycle ack.
//
// Address map:
//   0x00 PINB   0x01 PORTB   0x02 DDRB
//   0x03 PINC   0x04 PORTC   0x05 DDRC
//   0x06 PIND   0x07 PORTD   0x08 DDRD
//   0x09..0xFF unmapped: writes ignored, reads return 0x00, ack still given.
//
// Pin path: the dedicated chain is SYNC_STAGES-1 flops deep. A PINx read
// registers the chain output into read_data, so read_data acts as the final
// synchronizer stage for pin data. A change before edge E0 is therefore
// returned by a PINx read sampled at edge E0+SYNC_STAGES-1.
module io_port_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic       write_en,
    input  logic [7:0] write_data,
    input  logic       read_en,
    output logic [7:0] read_data,
    output logic       ack,
    input  logic [7:0] io_b_in,
    input  logic [7:0] io_c_in,
    input  logic [7:0] io_d_in,
    output logic [7:0] io_b_out,
    output logic [7:0] io_c_out,
    output logic [7:0] io_d_out,
    output logic [7:0] io_b_oe,
    output logic [7:0] io_c_oe,
    output logic [7:0] io_d_oe
);

    localparam int CHAIN = SYNC_STAGES - 1;

    logic [CHAIN-1:0][7:0] sync_b;
    logic [CHAIN-1:0][7:0] sync_c;
    logic [CHAIN-1:0][7:0] sync_d;

    logic [7:0] pin_b;
    logic [7:0] pin_c;
    logic [7:0] pin_d;

    logic [7:0] port_b;
    logic [7:0] port_c;
    logic [7:0] port_d;
    logic [7:0] ddr_b;
    logic [7:0] ddr_c;
    logic [7:0] ddr_d;

    logic       tog_b;
    logic       tog_c;
    logic       tog_d;
    logic       wr_port_b;
    logic       wr_port_c;
    logic       wr_port_d;
    logic       wr_ddr_b;
    logic       wr_ddr_c;
    logic       wr_ddr_d;
    logic [7:0] rd_mux;

    // Pin synchronizer chains, one per port, shifting every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_b <= '0;
            sync_c <= '0;
            sync_d <= '0;
        end else begin
            sync_b[0] <= io_b_in;
            sync_c[0] <= io_c_in;
            sync_d[0] <= io_d_in;
            for (int i = 1; i < CHAIN; i++) begin
                sync_b[i] <= sync_b[i-1];
                sync_c[i] <= sync_c[i-1];
                sync_d[i] <= sync_d[i-1];
            end
        end
    end

    assign pin_b = sync_b[CHAIN-1];
    assign pin_c = sync_c[CHAIN-1];
    assign pin_d = sync_d[CHAIN-1];

    // Address decode: per-register write strobes and the read mux.
    always_comb begin
        tog_b     = 1'b0;
        tog_c     = 1'b0;
        tog_d     = 1'b0;
        wr_port_b = 1'b0;
        wr_port_c = 1'b0;
        wr_port_d = 1'b0;
        wr_ddr_b  = 1'b0;
        wr_ddr_c  = 1'b0;
        wr_ddr_d  = 1'b0;
        rd_mux    = 8'h00;
        case (addr)
            8'h00: begin
                tog_b  = write_en;
                rd_mux = pin_b;
            end
            8'h01: begin
                wr_port_b = write_en;
                rd_mux    = port_b;
            end
            8'h02: begin
                wr_ddr_b = write_en;
                rd_mux   = ddr_b;
            end
            8'h03: begin
                tog_c  = write_en;
                rd_mux = pin_c;
            end
            8'h04: begin
                wr_port_c = write_en;
                rd_mux    = port_c;
            end
            8'h05: begin
                wr_ddr_c = write_en;
                rd_mux   = ddr_c;
            end
            8'h06: begin
                tog_d  = write_en;
                rd_mux = pin_d;
            end
            8'h07: begin
                wr_port_d = write_en;
                rd_mux    = port_d;
            end
            8'h08: begin
                wr_ddr_d = write_en;
                rd_mux   = ddr_d;
            end
            default: rd_mux = 8'h00;
        endcase
    end

    // PORTx registers: direct write, or toggle of set bits via a PINx write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            port_b <= 8'h00;
            port_c <= 8'h00;
            port_d <= 8'h00;
        end else begin
            if (wr_port_b)  port_b <= write_data;
            else if (tog_b) port_b <= port_b ^ write_data;
            if (wr_port_c)  port_c <= write_data;
            else if (tog_c) port_c <= port_c ^ write_data;
            if (wr_port_d)  port_d <= write_data;
            else if (tog_d) port_d <= port_d ^ write_data;
        end
    end

    // DDRx registers: plain write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ddr_b <= 8'h00;
            ddr_c <= 8'h00;
            ddr_d <= 8'h00;
        end else begin
            if (wr_ddr_b) ddr_b <= write_data;
            if (wr_ddr_c) ddr_c <= write_data;
            if (wr_ddr_d) ddr_d <= write_data;
        end
    end

    // Response: ack follows any request; read_data captures the pre-write
    // value on a read and otherwise holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack       <= 1'b0;
            read_data <= 8'h00;
        end else begin
            ack <= write_en | read_en;
            if (read_en) read_data <= rd_mux;
        end
    end

    assign io_b_out = port_b;
    assign io_c_out = port_c;
    assign io_d_out = port_d;
    assign io_b_oe  = ddr_b;
    assign io_c_oe  = ddr_c;
    assign io_d_oe  = ddr_d;

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: register model plus a queue of
// expected read results pushed at drive time and popped at the response.
module tb_io_port_unit;

    logic       clock;
    logic       reset_n;
    logic [7:0] addr;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;
    logic [7:0] read_data;
    logic       ack;
    logic [7:0] io_b_in, io_c_in, io_d_in;
    logic [7:0] io_b_out, io_c_out, io_d_out;
    logic [7:0] io_b_oe, io_c_oe, io_d_oe;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_port [3];
    logic [7:0] m_ddr  [3];
    logic [7:0] m_pin  [3];
    logic [7:0] last_rd;
    logic [7:0] exp_q [$];

    io_port_unit #(.SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addr       (addr),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .ack        (ack),
        .io_b_in    (io_b_in),
        .io_c_in    (io_c_in),
        .io_d_in    (io_d_in),
        .io_b_out   (io_b_out),
        .io_c_out   (io_c_out),
        .io_d_out   (io_d_out),
        .io_b_oe    (io_b_oe),
        .io_c_oe    (io_c_oe),
        .io_d_oe    (io_d_oe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a > 8'h08) return 8'h00;
        case (a % 3)
            0:       return m_pin[a / 3];
            1:       return m_port[a / 3];
            default: return m_ddr[a / 3];
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a <= 8'h08) begin
            case (a % 3)
                0:       m_port[a / 3] = m_port[a / 3] ^ d;
                1:       m_port[a / 3] = d;
                default: m_ddr[a / 3]  = d;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_port[k] = 8'h00;
            m_ddr[k]  = 8'h00;
        end
        last_rd = 8'h00;
        exp_q.delete();
    endtask

    task automatic check_pins_out();
        check("b_out", io_b_out, m_port[0]);
        check("c_out", io_c_out, m_port[1]);
        check("d_out", io_d_out, m_port[2]);
        check("b_oe",  io_b_oe,  m_ddr[0]);
        check("c_oe",  io_c_oe,  m_ddr[1]);
        check("d_oe",  io_d_oe,  m_ddr[2]);
    endtask

    // One request cycle; request stays on the bus until the next drive.
    task automatic do_req(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] e;
        @(negedge clock);
        write_en   = w;
        read_en    = r;
        addr       = a;
        write_data = d;
        if (r) exp_q.push_back(model_read(a));
        if (w) model_write(a, d);
        @(posedge clock);
        #1;
        check("ack", {7'b0, ack}, {7'b0, (w | r)});
        if (r) begin
            if (exp_q.size() == 0) begin
                check("rd_queue_empty", 8'h01, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check("read_data", read_data, e);
                last_rd = e;
            end
        end
        check_pins_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            write_en = 1'b0;
            read_en  = 1'b0;
            @(posedge clock);
            #1;
            check("idle_ack", {7'b0, ack}, 8'h00);
            check("idle_hold", read_data, last_rd);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        addr       = 8'h00;
        write_en   = 1'b0;
        write_data = 8'h00;
        read_en    = 1'b0;
        io_b_in    = 8'h3C;
        io_c_in    = 8'h00;
        io_d_in    = 8'hE7;
        m_pin[0]   = 8'h3C;
        m_pin[1]   = 8'h00;
        m_pin[2]   = 8'hE7;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_ack", {7'b0, ack}, 8'h00);
        check("rst_rdata", read_data, 8'h00);
        check_pins_out();
        @(negedge clock);
        reset_n = 1'b1;
        idle(3);

        // Write then read every PORT/DDR register.
        do_req(1, 0, 8'h01, 8'h5A);
        do_req(1, 0, 8'h02, 8'hC3);
        do_req(1, 0, 8'h04, 8'hA5);
        do_req(1, 0, 8'h05, 8'h3C);
        do_req(1, 0, 8'h07, 8'h0F);
        do_req(1, 0, 8'h08, 8'h96);
        do_req(0, 1, 8'h01, 8'h00);
        do_req(0, 1, 8'h02, 8'h00);
        do_req(0, 1, 8'h04, 8'h00);
        do_req(0, 1, 8'h05, 8'h00);
        do_req(0, 1, 8'h07, 8'h00);
        do_req(0, 1, 8'h08, 8'h00);
        idle(1);

        // Pin reads ignore DDR.
        do_req(0, 1, 8'h00, 8'h00);
        do_req(0, 1, 8'h06, 8'h00);
        idle(1);

        // Pin synchronization latency on port C.
        @(negedge clock);
        io_c_in = 8'h81;
        write_en = 1'b0;
        read_en  = 1'b1;
        addr     = 8'h03;
        exp_q.push_back(8'h00);
        @(posedge clock);
        #1;
        check("sync_1st_ack", {7'b0, ack}, 8'h01);
        check("sync_1st", read_data, exp_q.pop_front());
        m_pin[1] = 8'h81;
        do_req(0, 1, 8'h03, 8'h00);
        idle(1);

        // Toggle via PIND write.
        do_req(1, 0, 8'h07, 8'h0F);
        do_req(1, 0, 8'h06, 8'hFF);
        do_req(0, 1, 8'h07, 8'h00);
        idle(1);

        // Simultaneous read and write, then read-after-write.
        do_req(1, 0, 8'h01, 8'h11);
        do_req(1, 1, 8'h01, 8'h22);
        do_req(0, 1, 8'h01, 8'h00);
        do_req(1, 1, 8'h03, 8'h0C);
        do_req(0, 1, 8'h04, 8'h00);
        idle(1);

        // Out-of-range address.
        do_req(1, 0, 8'h09, 8'hFF);
        do_req(0, 1, 8'h09, 8'h00);
        do_req(1, 1, 8'hFF, 8'h77);
        idle(1);

        // Eight back-to-back reads.
        for (int i = 0; i < 8; i++) do_req(0, 1, 8'(i), 8'h00);
        idle(2);

        // Reset asserted mid-cycle with a write pending.
        @(negedge clock);
        write_en   = 1'b1;
        read_en    = 1'b0;
        addr       = 8'h01;
        write_data = 8'hAA;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mrst_ack", {7'b0, ack}, 8'h00);
        check("mrst_rdata", read_data, 8'h00);
        check_pins_out();
        @(posedge clock);
        #1;
        check("mrst_ack2", {7'b0, ack}, 8'h00);
        check("mrst_portb", io_b_out, 8'h00);
        @(negedge clock);
        write_en = 1'b0;
        reset_n  = 1'b1;
        idle(2);
        do_req(0, 1, 8'h01, 8'h00);
        do_req(0, 1, 8'h00, 8'h00);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
